cla_adder4: RTL and testbench



---
 rtl/cla_pkg.sv | 16 +
 rtl/cla4_pg.sv | 60 ++++++
 rtl/cla_adder4.sv | 112 +++++++++++
 tb/tb_cla_adder4.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the 4-bit carry-lookahead adder slice.
//   CLA_W    : slice width in bits
//   nibble_t : one slice-wide operand or result
//   SUM_RST  : value the registered sum takes while reset is asserted
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_W = 4;

  typedef logic [CLA_W-1:0] nibble_t;

  localparam nibble_t SUM_RST = 4'h0;

endpackage : cla_pkg

// File: rtl/cla4_pg.sv
// ---------------------------------------------------------------------------
// cla4_pg
// Purely combinational 4-bit carry-lookahead core: generate/propagate terms,
// flat (non-rippling) carry expansion and the sum bits.
// Ports:
//   A, B  (in,  4) addends
//   c_in  (in,  1) carry in (becomes c0)
//   s     (out, 4) sum bits, s[i] = p[i] ^ c[i]
//   c_out (out, 1) carry out of bit 3 (c4)
// ---------------------------------------------------------------------------
module cla4_pg
  import cla_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  nibble_t    g;
  nibble_t    p;
  logic [4:0] c;

  genvar gi;

  generate
    for (gi = 0; gi < CLA_W; gi++) begin : g_pg
      assign g[gi] = A[gi] & B[gi];
      assign p[gi] = A[gi] ^ B[gi];
    end
  endgenerate

  // Every carry is expanded directly from g, p and c_in so no carry depends
  // on a lower carry; the depth stays two levels for every bit.
  assign c[0] = c_in;
  assign c[1] = g[0]
              | (p[0] & c_in);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c_in);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  generate
    for (gi = 0; gi < CLA_W; gi++) begin : g_sum
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign c_out = c[4];

endmodule : cla4_pg

// File: rtl/cla_adder4.sv
// ---------------------------------------------------------------------------
// cla_adder4
// 4-bit carry-lookahead adder slice with an enable-gated result register and
// a ready flag. Slices chain through c_out -> c_in combinationally.
// Subtraction is handled by the parent (B pre-inverted, c_in = 1).
// Ports:
//   clk    (in,  1) rising-edge clock
//   rst_n  (in,  1) asynchronous active-low reset
//   en     (in,  1) capture enable
//   c_in   (in,  1) carry in
//   A, B   (in,  4) addends
//   Output (out, 4) registered sum
//   c_out  (out, 1) combinational carry out
//   ready  (out, 1) Output holds the result captured on the last edge
// Build option:
//   CLA_ADDER4_IN_REG_EN - register A, B, c_in on en first; Output follows
//   one edge later (2-cycle latency), ready is en delayed by two edges and
//   c_out is computed from the registered inputs.
// ---------------------------------------------------------------------------
module cla_adder4
  import cla_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       c_in,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Output,
  output logic       c_out,
  output logic       ready
);

  nibble_t sum_next;
  nibble_t sum_reg;
  logic    ready_reg;

`ifdef CLA_ADDER4_IN_REG_EN

  nibble_t a_reg;
  nibble_t b_reg;
  logic    cin_reg;
  logic    en_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      cin_reg  <= 1'b0;
      en_d_reg <= 1'b0;
    end else begin
      en_d_reg <= en;
      if (en) begin
        a_reg   <= A;
        b_reg   <= B;
        cin_reg <= c_in;
      end
    end
  end

  cla4_pg u_pg (
    .A     (a_reg),
    .B     (b_reg),
    .c_in  (cin_reg),
    .s     (sum_next),
    .c_out (c_out)
  );

  // The output stage captures whenever the input stage captured on the
  // previous edge, so ready is en shifted through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= SUM_RST;
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= en_d_reg;
      if (en_d_reg) begin
        sum_reg <= sum_next;
      end
    end
  end

`else

  // c_out comes straight from the live inputs so a downstream slice
  // clocked on the same edge captures the correct carry.
  cla4_pg u_pg (
    .A     (A),
    .B     (B),
    .c_in  (c_in),
    .s     (sum_next),
    .c_out (c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= SUM_RST;
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= en;
      if (en) begin
        sum_reg <= sum_next;
      end
    end
  end

`endif

  assign Output = sum_reg;
  assign ready  = ready_reg;

endmodule : cla_adder4

// File: tb/tb_cla_adder4.sv
// ---------------------------------------------------------------------------
// tb_cla_adder4
// Self-checking bench for cla_adder4: a table of directed vectors, hand
// sequences for hold / reset / two-slice chaining, and an exhaustive sweep.
// Expected sums are queued at drive time and popped when ready is seen.
// ---------------------------------------------------------------------------
module tb_cla_adder4;

`ifdef CLA_ADDER4_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       c_in;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sum;
  logic       c_out;
  logic       ready;

  // second pair of slices forming an 8-bit adder
  logic       en_c;
  logic [3:0] a_lo, b_lo, a_hi, b_hi;
  logic       cin_lo;
  logic [3:0] sum_lo, sum_hi;
  logic       cout_lo, cout_hi;
  logic       rdy_lo, rdy_hi;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] sb[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
  } vec_t;

  vec_t tbl[7];

  cla_adder4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .c_in   (c_in),
    .A      (a),
    .B      (b),
    .Output (sum),
    .c_out  (c_out),
    .ready  (ready)
  );

  cla_adder4 u_lo (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en_c),
    .c_in   (cin_lo),
    .A      (a_lo),
    .B      (b_lo),
    .Output (sum_lo),
    .c_out  (cout_lo),
    .ready  (rdy_lo)
  );

  cla_adder4 u_hi (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en_c),
    .c_in   (cout_lo),
    .A      (a_hi),
    .B      (b_hi),
    .Output (sum_hi),
    .c_out  (cout_hi),
    .ready  (rdy_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  // Scoreboard: every edge that reports ready must deliver the oldest
  // queued sum.
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (sb.size() == 0) begin
        check("ready_without_pending", {7'd0, ready}, 8'd0);
      end else begin
        check("sum", {4'd0, sum}, {4'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] full;

    tbl[0] = '{a: 4'h3, b: 4'h5, ci: 1'b0, s: 4'h8, co: 1'b0};
    tbl[1] = '{a: 4'hF, b: 4'h0, ci: 1'b1, s: 4'h0, co: 1'b1};
    tbl[2] = '{a: 4'h7, b: 4'hD, ci: 1'b1, s: 4'h5, co: 1'b1};
    tbl[3] = '{a: 4'hF, b: 4'h1, ci: 1'b0, s: 4'h0, co: 1'b1};
    tbl[4] = '{a: 4'h0, b: 4'h0, ci: 1'b0, s: 4'h0, co: 1'b0};
    tbl[5] = '{a: 4'hA, b: 4'h5, ci: 1'b1, s: 4'h0, co: 1'b1};
    tbl[6] = '{a: 4'h9, b: 4'h6, ci: 1'b0, s: 4'hF, co: 1'b0};

    rst_n = 1'b0; en = 1'b0; c_in = 1'b0; a = 4'h0; b = 4'h0;
    en_c = 1'b0; a_lo = 4'h0; b_lo = 4'h0; cin_lo = 1'b0; a_hi = 4'h0; b_hi = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", {4'd0, sum}, 8'h00);
    check("reset_ready", {7'd0, ready}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed table, one vector at a time ----
    for (int i = 0; i < 7; i++) begin
      a = tbl[i].a; b = tbl[i].b; c_in = tbl[i].ci; en = 1'b1;
      sb.push_back(tbl[i].s);
`ifndef CLA_ADDER4_IN_REG_EN
      #1 check("tbl_cout", {7'd0, c_out}, {7'd0, tbl[i].co});
`endif
      @(posedge clk); #1;
`ifdef CLA_ADDER4_IN_REG_EN
      check("tbl_cout", {7'd0, c_out}, {7'd0, tbl[i].co});
`endif
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    check("tbl_drain", sb.size(), 0);

    // ---- basic add then hold with en low ----
    a = 4'h3; b = 4'h5; c_in = 1'b0; en = 1'b1;
    sb.push_back(4'h8);
    @(posedge clk); #1;
    en = 1'b0; a = 4'hC; b = 4'hC;
    repeat (LAT) @(posedge clk);
    #1;
    check("hold_ready_low", {7'd0, ready}, 8'h00);
    check("hold_sum", {4'd0, sum}, 8'h08);
    repeat (2) @(posedge clk);
    #1;
    check("hold_sum_later", {4'd0, sum}, 8'h08);

    // ---- asynchronous reset mid-run, reset beats en ----
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", {4'd0, sum}, 8'h00);
    check("async_rst_ready", {7'd0, ready}, 8'h00);
    a = 4'h3; b = 4'h5; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wins_sum", {4'd0, sum}, 8'h00);
    check("rst_wins_ready", {7'd0, ready}, 8'h00);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_ready", {7'd0, ready}, 8'h00);
    check("post_rst_sum", {4'd0, sum}, 8'h00);

    // ---- two slices chained into 8 bits: 8'h8F + 8'h01 ----
    a_lo = 4'hF; b_lo = 4'h1; cin_lo = 1'b0;
    a_hi = 4'h8; b_hi = 4'h0; en_c = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    en_c = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("chain_sum8", {sum_hi, sum_lo}, 8'h90);
    check("chain_ready", {6'd0, rdy_hi, rdy_lo}, 8'h03);

    // ---- exhaustive stream, en held high ----
    for (int i = 0; i < 512; i++) begin
      a = i[3:0]; b = i[7:4]; c_in = i[8]; en = 1'b1;
      full = {1'b0, a} + {1'b0, b} + {4'd0, c_in};
      sb.push_back(full[3:0]);
`ifndef CLA_ADDER4_IN_REG_EN
      #1;
      if (c_out !== full[4]) check("sweep_cout", {7'd0, c_out}, {7'd0, full[4]});
`endif
      @(posedge clk); #1;
`ifdef CLA_ADDER4_IN_REG_EN
      if (c_out !== full[4]) check("sweep_cout", {7'd0, c_out}, {7'd0, full[4]});
`endif
      if (i >= LAT - 1 && ready !== 1'b1) check("sweep_ready", {7'd0, ready}, 8'h01);
    end
    en = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("sweep_drain", sb.size(), 0);
    check("sweep_ready_drop", {7'd0, ready}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_cla_adder4
